// File: rtl/conv_mac_pipe.sv
// conv_mac_pipe: pipelined signed multiply-accumulate with framed sums, rounding shift and saturation.
module conv_mac_pipe #(
   parameter int DIN0_WIDTH = 8,
   parameter int DIN1_WIDTH = 16,
   parameter int NUM_STAGE  = 2,
   parameter int ACC_WIDTH  = 32,
   parameter int SHIFT      = 0,
   parameter int DOUT_WIDTH = 24
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic                         in_valid,
   input  logic                         in_first,
   input  logic                         in_last,
   input  logic signed [DIN0_WIDTH-1:0] din0,
   input  logic signed [DIN1_WIDTH-1:0] din1,
   output logic                         out_valid,
   output logic signed [DOUT_WIDTH-1:0] dout,
   output logic                         ovf
);
   localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
   localparam int AW1 = ACC_WIDTH + 1;
   localparam int LS  = NUM_STAGE - 1;
   localparam logic [AW1-1:0] ONE = AW1'(1);
   localparam logic [AW1-1:0] RND = (ONE << SHIFT) >> 1;
   localparam logic signed [AW1-1:0] MAXV = $signed((ONE << (DOUT_WIDTH - 1)) - ONE);
   localparam logic signed [AW1-1:0] MINV = ~MAXV;

   logic signed [PW-1:0]         prod_q [NUM_STAGE];
   logic [NUM_STAGE-1:0]         vld_q, fst_q, lst_q;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic                         prev_last_q, done_q;
   logic signed [AW1-1:0]        r;
   logic signed [DOUT_WIDTH-1:0] dout_d;
   logic                         ovf_d;

   // prev_last_q makes any term following a completed sum an implicit start
   always_comb begin
      acc_d  = (fst_q[LS] | prev_last_q) ? ACC_WIDTH'(prod_q[LS]) : acc_q + ACC_WIDTH'(prod_q[LS]);
      r      = (AW1'(acc_q) + $signed(RND)) >>> SHIFT;
      ovf_d  = (r > MAXV) | (r < MINV);
      dout_d = r > MAXV ? MAXV[DOUT_WIDTH-1:0] : r < MINV ? MINV[DOUT_WIDTH-1:0] : r[DOUT_WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
         vld_q       <= '0;
         fst_q       <= '0;
         lst_q       <= '0;
         acc_q       <= '0;
         prev_last_q <= 1'b1;
         done_q      <= 1'b0;
         out_valid   <= 1'b0;
         dout        <= '0;
         ovf         <= 1'b0;
      end else if (ce) begin
         prod_q[0] <= din0 * din1;
         vld_q[0]  <= in_valid;
         fst_q[0]  <= in_first;
         lst_q[0]  <= in_last;
         for (int i = 1; i < NUM_STAGE; i++) begin
            prod_q[i] <= prod_q[i-1];
            vld_q[i]  <= vld_q[i-1];
            fst_q[i]  <= fst_q[i-1];
            lst_q[i]  <= lst_q[i-1];
         end
         if (vld_q[LS]) begin
            acc_q       <= acc_d;
            prev_last_q <= lst_q[LS];
         end
         done_q    <= vld_q[LS] & lst_q[LS];
         out_valid <= done_q;
         if (done_q) begin
            dout <= dout_d;
            ovf  <= ovf_d;
         end
      end
   end
endmodule

// File: tb/tb_conv_mac_pipe.sv
// tb_conv_mac_pipe: scoreboard bench for a default build and a SHIFT=4 build of conv_mac_pipe.
module tb_conv_mac_pipe;
   logic clk = 1'b0;
   logic reset, ce, in_valid, in_first, in_last;
   logic signed [7:0]  din0;
   logic signed [15:0] din1;
   logic out_valid, ovf;
   logic signed [23:0] dout;

   logic s_ce = 1'b1;
   logic s_valid, s_first, s_last;
   logic signed [7:0]  s_din0;
   logic signed [15:0] s_din1;
   logic s_out_valid, s_ovf;
   logic signed [23:0] s_dout;

   typedef struct {
      logic signed [23:0] d;
      logic               o;
   } exp_t;

   exp_t exp_q[$];
   exp_t s_q[$];
   int   lat_q[$];
   exp_t me, se;
   int   errors = 0, checks = 0, en_cnt = 0;
   bit   ce_edge = 1'b0, was_ok = 1'b0;
   logic pv;
   logic signed [23:0] pd;

   always #5 clk = ~clk;

   conv_mac_pipe dut (
      .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
      .in_last(in_last), .din0(din0), .din1(din1), .out_valid(out_valid), .dout(dout), .ovf(ovf)
   );

   conv_mac_pipe #(.SHIFT(4)) dut_s (
      .clk(clk), .reset(reset), .ce(s_ce), .in_valid(s_valid), .in_first(s_first),
      .in_last(s_last), .din0(s_din0), .din1(s_din1), .out_valid(s_out_valid), .dout(s_dout), .ovf(s_ovf)
   );

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // Edge bookkeeping and output checking for the default build
   always @(posedge clk) begin
      ce_edge = ce && !reset;
      if (ce_edge) begin
         en_cnt++;
         if (in_valid && in_last) lat_q.push_back(en_cnt + 3);
      end
      #1;
      if (reset) was_ok = 1'b0;
      else begin
         if (ce_edge) begin
            if (out_valid) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected out_valid: dout=%0d", dout);
               end else begin
                  me = exp_q.pop_front();
                  chk("dout", dout, me.d);
                  chk("ovf", ovf, me.o);
                  chk("latency_edge", en_cnt, lat_q.size() ? lat_q.pop_front() : -1);
               end
            end
         end else if (was_ok) begin
            chk("hold_out_valid", out_valid, pv);
            chk("hold_dout", dout, pd);
         end
         pv = out_valid;
         pd = dout;
         was_ok = 1'b1;
      end
   end

   always @(posedge clk) begin
      #1;
      if (!reset && s_out_valid) begin
         if (s_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected s_out_valid: dout=%0d", s_dout);
         end else begin
            se = s_q.pop_front();
            chk("shift_dout", s_dout, se.d);
            chk("shift_ovf", s_ovf, se.o);
         end
      end
   end

   task automatic term(input int a, input int b, input bit f, input bit l);
      @(negedge clk);
      ce = 1; in_valid = 1; in_first = f; in_last = l; din0 = 8'(a); din1 = 16'(b);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         ce = 1; in_valid = 0; in_first = 0; in_last = 0;
      end
   endtask

   // Frozen cycles carry junk terms that must be ignored
   task automatic freeze(input int n);
      repeat (n) begin
         @(negedge clk);
         ce = 0; in_valid = 1; in_first = 1; in_last = 1; din0 = 8'sd99; din1 = 16'sd99;
      end
   endtask

   task automatic expect_out(input int d, input bit o);
      exp_t e;
      e.d = 24'(d);
      e.o = o;
      exp_q.push_back(e);
   endtask

   task automatic s_term(input int a, input int b, input bit f, input bit l, input int d);
      exp_t e;
      @(negedge clk);
      s_valid = 1; s_first = f; s_last = l; s_din0 = 8'(a); s_din1 = 16'(b);
      if (l) begin
         e.d = 24'(d);
         e.o = 1'b0;
         s_q.push_back(e);
      end
   endtask

   initial begin
      reset = 1; ce = 0; in_valid = 0; in_first = 0; in_last = 0; din0 = 0; din1 = 0;
      s_valid = 0; s_first = 0; s_last = 0; s_din0 = 0; s_din1 = 0;
      repeat (2) @(negedge clk);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_dout", dout, 0);
      chk("reset_ovf", ovf, 0);
      chk("reset_s_out_valid", s_out_valid, 0);
      reset = 0;
      idle(2);

      // extreme operands, single-term sum
      term(-128, -32768, 1, 1); expect_out(4194304, 0);
      idle(6);

      // bubbles and implicit first
      term(1, 10, 1, 1); expect_out(10, 0);
      idle(1);
      term(2, 5, 0, 0);
      term(1, 1, 0, 1); expect_out(11, 0);
      idle(6);

      // clock-enable stalls between terms and over the output pulse
      term(3, 100, 1, 0);
      freeze(3);
      term(-2, 50, 0, 0);
      freeze(3);
      term(127, 32767, 0, 1); expect_out(4161609, 0);
      idle(3);
      freeze(2);
      idle(4);

      // back-to-back sums, plain then saturating both ways
      term(3, 100, 1, 0);
      term(-2, 50, 0, 0);
      term(127, 32767, 0, 1); expect_out(4161609, 0);
      term(127, 32767, 1, 0);
      term(127, 32767, 0, 0);
      term(127, 32767, 0, 1); expect_out(8388607, 1);
      term(-128, 32767, 1, 0);
      term(-128, 32767, 0, 0);
      term(-128, 32767, 0, 1); expect_out(-8388608, 1);
      idle(6);

      // reset aborts a partial sum
      term(1, 2, 1, 0);
      term(3, 4, 0, 0);
      @(negedge clk);
      reset = 1; in_valid = 0;
      #1;
      chk("midreset_out_valid", out_valid, 0);
      chk("midreset_dout", dout, 0);
      chk("midreset_ovf", ovf, 0);
      @(negedge clk);
      reset = 0;
      term(5, 5, 1, 1); expect_out(25, 0);
      idle(6);

      // rounding shift build
      s_term(4, 4, 1, 0, 0);
      s_term(2, 4, 0, 1, 2);
      s_term(-3, 8, 1, 1, -1);
      s_term(2, 4, 1, 1, 1);
      s_term(7, 1, 1, 1, 0);
      s_term(-9, 1, 1, 1, -1);
      s_term(-8, 1, 1, 1, 0);
      @(negedge clk);
      s_valid = 0;

      for (int i = 0; i < 50 && (exp_q.size() != 0 || s_q.size() != 0); i++) @(negedge clk);
      idle(3);
      checks++;
      if (exp_q.size() != 0 || s_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: pending %0d/%0d expected outputs never appeared", exp_q.size(), s_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conv_mac_pipe.md
Name: conv_mac_pipe

Overview:
Parametrised, pipelined signed multiply-accumulate unit for the CNN convolution datapaths. It is the successor to the fixed 8x16 combinational multiplier cores. It multiplies a weight stream by an activation stream and accumulates the products over a frame delimited by first/last flags. Each finished sum is rounded, shifted and saturated to the output width. It sits between the line-buffer/window logic and the conv output FIFO.

Parameters:
DIN0_WIDTH, 8, signed width of din0 (weight)
DIN1_WIDTH, 16, signed width of din1 (activation)
NUM_STAGE, 2, product pipeline registers (>=1)
ACC_WIDTH, 32, accumulator width (>= DIN0_WIDTH+DIN1_WIDTH)
SHIFT, 0, arithmetic right shift applied to the final sum (0..ACC_WIDTH-1)
DOUT_WIDTH, 24, signed output width (<= ACC_WIDTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
ce  in  1  clock enable; 0 freezes every register
in_valid  in  1  din0/din1/in_first/in_last valid this cycle
in_first  in  1  first term of a sum
in_last  in  1  last term of a sum
din0  in  DIN0_WIDTH  signed operand
din1  in  DIN1_WIDTH  signed operand
out_valid  out  1  dout/ovf valid, one enabled-cycle pulse
dout  out  DOUT_WIDTH  rounded, saturated sum
ovf  out  1  saturation occurred for this dout

Behaviour:
- Reset (asynchronous, active-high) clears all pipeline registers, valid/first/last shadows and the accumulator.
- Reset values: out_valid=0, dout=0, ovf=0.
- A reset mid-sum discards every partial sum. The first valid term after reset starts a new sum.
- Input sampling: an input is sampled on a rising edge only when ce=1 and in_valid=1. When in_valid=0 a bubble travels the pipe and causes no accumulator change.
- Product: full-precision signed product of width DIN0_WIDTH+DIN1_WIDTH, delayed through NUM_STAGE registers. in_valid, in_first and in_last are delayed alongside the product.
- Accumulator: on the enabled edge after a valid product leaves the pipe:
  - acc = prod (sign-extended) if the term is a start term;
  - otherwise acc = acc + prod.
  - Arithmetic wraps modulo 2^ACC_WIDTH. Accumulator wrap is not flagged.
- Start term: a term is a start term when its in_first=1, or when the previous valid term had in_last=1 (implicit first). A term with in_first and in_last both high is a single-term sum.
- Output stage: on the enabled edge after the accumulator absorbs a last term:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed at ACC_WIDTH+1 bits so the rounding add cannot overflow (round half up);
  - dout = r clamped to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1];
  - ovf = 1 if clamping occurred, else 0;
  - out_valid = 1.
- On any other enabled edge out_valid=0, while dout and ovf hold their last values.
- Latency: out_valid is high after the (NUM_STAGE+2)-th enabled rising edge, counting the edge that samples the last term as edge 1. With the defaults that is 4 edges.
- Throughput: one term per enabled cycle with no back-pressure. Back-to-back sums are allowed: in_last on one cycle and in_first on the next.
- ce=0: all state holds, including out_valid. A pulse present while ce=0 stays visible until the next enabled edge. Inputs are ignored while ce=0.
- The pipeline stays correct for any interleaving of ce, in_valid and the first/last flags.

Test Plan:
1. Defaults; din0=-128, din1=-32768, first=last=1 -> 4 enabled edges later out_valid=1 for one cycle, dout=4194304, ovf=0.
2. Three consecutive terms (3,100), (-2,50), (127,32767), first on term 1, last on term 3 -> dout=4161609, ovf=0. Repeat with three terms of (127,32767) -> dout=8388607, ovf=1. Repeat with (-128,32767) x3 -> dout=-8388608, ovf=1.
3. Test 2 first stream with ce=0 for 3 cycles between terms and a 2-cycle ce=0 while out_valid=1 -> same dout; out_valid stays high exactly until the next enabled edge; total latency counted in enabled edges is unchanged.
4. Bubbles and implicit first: (1,10) first+last, idle cycle, then (2,5) and (1,1) with first=0 and last on the second -> outputs 10 then 11.
5. SHIFT=4 build: sum 24 -> dout=2; sum -24 -> dout=-1; sum 8 -> dout=1.
6. Assert reset for 1 cycle after 2 terms of a 3-term sum, then a fresh (5,5) first+last -> no output from the aborted sum; dout=25; out_valid, dout and ovf are 0 during reset.
